// File: rtl/vdp_lite_pkg.sv
// Shared constants and requester identities for the character ROM path.
package vdp_lite_pkg;

    localparam int CHAR_ROM_ADDR_WIDTH = 10;
    localparam int CHAR_ROM_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        REQ_TILE  = 3'd0,
        REQ_LAYER = 3'd1,
        REQ_HOST  = 3'd2
    } req_idx_e;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating first-one finder: picks the first set mask bit after ptr, wrapping around.
module rr_priority_select #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req_mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 found
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + 1 + k) % N);
            if (!found && req_mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_rom_arbiter.sv
// Character ROM arbiter: fixed-priority tile fetcher, round-robin for the rest, starvation override.
module char_rom_arbiter
    import vdp_lite_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = CHAR_ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = CHAR_ROM_DATA_WIDTH,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ADDR_WIDTH-1:0]         rom_address,
    input  logic [DATA_WIDTH-1:0]         rom_read_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int HI    = int'(REQ_TILE);

    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   starve_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starved_mask, low_mask;
    logic [NUM_REQ-1:0] starve_grant, rr_grant, grant;
    logic               starve_found, rr_found;
    logic [IDX_W-1:0]   grant_idx;

    always_comb begin
        starved_mask = '0;
        low_mask     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            low_mask[i]     = (i != HI) && req_valid[i];
            starved_mask[i] = low_mask[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Pointer 0 makes the starved search start at index 1, i.e. lowest index wins.
    rr_priority_select #(.N(NUM_REQ)) u_starve_sel (
        .req_mask (starved_mask),
        .ptr      (IDX_W'(0)),
        .grant    (starve_grant),
        .found    (starve_found)
    );

    rr_priority_select #(.N(NUM_REQ)) u_rr_sel (
        .req_mask (low_mask),
        .ptr      (rr_ptr),
        .grant    (rr_grant),
        .found    (rr_found)
    );

    always_comb begin
        grant = '0;
        if (!reset_n) begin
            grant = '0;
        end else if (starve_found) begin
            grant = starve_grant;
        end else if (req_valid[HI]) begin
            grant[HI] = 1'b1;
        end else if (rr_found) begin
            grant = rr_grant;
        end
    end

    always_comb begin
        rom_address = '0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                rom_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                grant_idx   = IDX_W'(i);
            end
        end
    end

    assign req_ready = grant;
    assign resp_data = rom_read_data;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
        end else begin
            resp_valid <= grant;
            if (|grant && grant_idx != IDX_W'(HI)) rr_ptr <= grant_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == HI || !req_valid[i] || grant[i])
                    starve_cnt[i] <= '0;
                else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT))
                    starve_cnt[i] <= starve_cnt[i] + 1'b1;
            end
        end
    end

endmodule
